// File: rtl/ball_track_if.sv
// rtl/ball_track_if.sv - player buttons and court outputs of the ball tracker
interface ball_track_if #(
   parameter int N_POS = 16
);
   logic             hit_one;
   logic             hit_two;
   logic             squash_en;
   logic [N_POS-1:0] pos;
   logic             hittable_one;
   logic             hittable_two;
   logic             in_play;
   logic             point_one;
   logic             point_two;
   logic [7:0]       rally_cnt;

   // Player / controller side: drives the buttons, watches the court.
   modport master (
      output hit_one, hit_two, squash_en,
      input  pos, hittable_one, hittable_two, in_play, point_one, point_two, rally_cnt
   );

   // Tracker side.
   modport slave (
      input  hit_one, hit_two, squash_en,
      output pos, hittable_one, hittable_two, in_play, point_one, point_two, rally_cnt
   );
endinterface

// File: rtl/ball_track.sv
// rtl/ball_track.sv - ball position, rally speed-up and scoring for a two-player LED court
module ball_track #(
   parameter int          N_POS       = 16,
   parameter int          CNT_W       = 25,
   parameter int unsigned INIT_PERIOD = 33554431,
   parameter int unsigned SPEED_STEP  = 3355443,
   parameter int unsigned MIN_PERIOD  = 2,
   parameter int          HIT_WIN     = 2
) (
   input logic         clk,
   input logic         rst,
   ball_track_if.slave bus
);

   localparam int IDX_W = $clog2(N_POS);

   localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_POS - 1);
   localparam logic [IDX_W-1:0] IDX_WIN_TWO = IDX_W'(N_POS - HIT_WIN);
   localparam logic [IDX_W-1:0] IDX_WIN_ONE = IDX_W'(HIT_WIN);
   localparam logic [IDX_W-1:0] IDX_STEP    = IDX_W'(1);

   localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(INIT_PERIOD);
   localparam logic [CNT_W-1:0] PERIOD_MIN  = CNT_W'(MIN_PERIOD);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   // Period arithmetic is done one bit wider so the floor test cannot wrap.
   localparam logic [CNT_W:0]   STEP_EXT    = (CNT_W+1)'(SPEED_STEP);
   localparam logic [CNT_W:0]   FLOOR_EXT   = (CNT_W+1)'(MIN_PERIOD) + STEP_EXT;

   localparam logic [7:0]       RALLY_MAX   = 8'd255;
   localparam logic [7:0]       RALLY_ONE   = 8'd1;
   localparam logic [N_POS-1:0] POS_ONE     = N_POS'(1);

   localparam logic [1:0] SERVE_ONE = 2'd0;
   localparam logic [1:0] SERVE_TWO = 2'd1;
   localparam logic [1:0] MOVE_R    = 2'd2;
   localparam logic [1:0] MOVE_L    = 2'd3;

   logic [1:0]       state;
   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] period;
   logic [7:0]       rally;
   logic             prev_two;      // last rally was served by player two
   logic             point_one_q;
   logic             point_two_q;

   logic             moving;
   logic             win_one;
   logic             win_two;
   logic             serve_r;
   logic             serve_l;
   logic             ret;
   logic             tick;
   logic             at_end;
   logic             miss;
   logic             step;
   logic             serve_one_next;
   logic [CNT_W:0]   period_ext;
   logic [CNT_W-1:0] period_fast;

   assign moving  = (state == MOVE_R) || (state == MOVE_L);
   assign win_two = (state == MOVE_R) && (idx >= IDX_WIN_TWO);
   assign win_one = (state == MOVE_L) && (idx <  IDX_WIN_ONE);

   assign serve_r = (state == SERVE_ONE) && bus.hit_one;
   assign serve_l = (state == SERVE_TWO) && bus.hit_two;

   // A return takes priority over the step timer firing in the same cycle.
   assign ret     = (win_two && bus.hit_two) || (win_one && bus.hit_one);
   assign tick    = moving && (cnt == period - CNT_ONE);
   assign at_end  = ((state == MOVE_R) && (idx == IDX_LAST)) ||
                    ((state == MOVE_L) && (idx == '0));
   assign miss    = tick && !ret && at_end;
   assign step    = tick && !ret && !at_end;

   // Squash keeps player one on serve; otherwise service alternates.
   assign serve_one_next = bus.squash_en || prev_two;

   assign period_ext  = {1'b0, period};
   assign period_fast = (period_ext >= FLOOR_EXT) ? CNT_W'(period_ext - STEP_EXT) : PERIOD_MIN;

   // Rally phase: serve, direction reversals on returns, back to serve on a miss.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= SERVE_ONE;
      end else if (serve_r) begin
         state <= MOVE_R;
      end else if (serve_l) begin
         state <= MOVE_L;
      end else if (ret) begin
         state <= (state == MOVE_R) ? MOVE_L : MOVE_R;
      end else if (miss) begin
         state <= serve_one_next ? SERVE_ONE : SERVE_TWO;
      end
   end

   // Ball index: parked at the server's end on a miss, one step per tick otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx <= '0;
      end else if (miss) begin
         idx <= serve_one_next ? '0 : IDX_LAST;
      end else if (step) begin
         idx <= (state == MOVE_R) ? idx + IDX_STEP : idx - IDX_STEP;
      end
   end

   // Step timer: idle while serving, restarts on every tick and every return.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!moving || ret || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_ONE;
      end
   end

   // Step period: shrinks on each return down to the floor, restored when the point ends.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period <= PERIOD_INIT;
      end else if (miss) begin
         period <= PERIOD_INIT;
      end else if (ret) begin
         period <= period_fast;
      end
   end

   // Return counter for the current rally, saturating.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rally <= '0;
      end else if (miss) begin
         rally <= '0;
      end else if (ret && (rally != RALLY_MAX)) begin
         rally <= rally + RALLY_ONE;
      end
   end

   // Remember who served so the next serve can alternate.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_two <= 1'b1;
      end else if (serve_r) begin
         prev_two <= 1'b0;
      end else if (serve_l) begin
         prev_two <= 1'b1;
      end
   end

   // One-cycle point pulses, raised on the same edge that enters the serve state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         point_one_q <= 1'b0;
         point_two_q <= 1'b0;
      end else begin
         point_one_q <= miss && (state == MOVE_R);
         point_two_q <= miss && (state == MOVE_L);
      end
   end

   assign bus.pos          = POS_ONE << idx;
   assign bus.hittable_one = win_one;
   assign bus.hittable_two = win_two;
   assign bus.in_play      = moving;
   assign bus.point_one    = point_one_q;
   assign bus.point_two    = point_two_q;
   assign bus.rally_cnt    = rally;

endmodule

// File: tb/tb_ball_track.sv
// tb/tb_ball_track.sv - scoreboard bench for ball_track with a countdown-based court model
module tb_ball_track;

   localparam int N    = 8;
   localparam int HW   = 2;
   localparam int INIT = 4;
   localparam int STEP = 1;
   localparam int MINP = 2;

   typedef struct packed {
      logic [7:0] pos;
      logic       h1;
      logic       h2;
      logic       ip;
      logic       p1;
      logic       p2;
      logic [7:0] rally;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   // Court model: ball index, direction (0 = waiting for serve), clocks until next step.
   int m_ball, m_dir, m_server, m_last, m_wait, m_period, m_rally, m_p1, m_p2;

   ball_track_if #(.N_POS(N)) bus();

   ball_track #(
      .N_POS(N), .CNT_W(8), .INIT_PERIOD(INIT), .SPEED_STEP(STEP),
      .MIN_PERIOD(MINP), .HIT_WIN(HW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // 10-unit clock.
   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_ball = 0; m_dir = 0; m_server = 1; m_last = 2; m_wait = 0;
      m_period = INIT; m_rally = 0; m_p1 = 0; m_p2 = 0;
   endfunction

   function automatic void model_step(input bit h1, input bit h2, input bit sq);
      m_p1 = 0;
      m_p2 = 0;
      if (m_dir == 0) begin
         if (m_server == 1 && h1) begin
            m_dir = 1; m_last = 1; m_wait = m_period;
         end else if (m_server == 2 && h2) begin
            m_dir = -1; m_last = 2; m_wait = m_period;
         end
      end else if ((m_dir == 1 && h2 && m_ball >= N - HW) || (m_dir == -1 && h1 && m_ball < HW)) begin
         m_dir = -m_dir;
         m_period = (m_period - STEP < MINP) ? MINP : m_period - STEP;
         if (m_rally < 255) m_rally++;
         m_wait = m_period;
      end else if (m_wait > 1) begin
         m_wait--;
      end else begin
         m_wait = m_period;
         if (m_ball + m_dir < 0 || m_ball + m_dir > N - 1) begin
            if (m_dir == 1) m_p1 = 1; else m_p2 = 1;
            m_server = (sq || m_last == 2) ? 1 : 2;
            m_dir = 0;
            m_ball = (m_server == 1) ? 0 : N - 1;
            m_period = INIT;
            m_rally = 0;
         end else begin
            m_ball += m_dir;
         end
      end
   endfunction

   function automatic void push_exp();
      exp_t e;
      e.pos   = 8'(1 << m_ball);
      e.h1    = (m_dir == -1 && m_ball < HW);
      e.h2    = (m_dir == 1 && m_ball >= N - HW);
      e.ip    = (m_dir != 0);
      e.p1    = (m_p1 != 0);
      e.p2    = (m_p2 != 0);
      e.rally = 8'(m_rally);
      exp_q.push_back(e);
   endfunction

   // One clock of stimulus: drive at negedge, advance the model, queue the post-edge outputs.
   task automatic cycle(input bit h1, input bit h2, input bit sq, input bit r);
      @(negedge clk);
      bus.hit_one   = h1 && !r;
      bus.hit_two   = h2 && !r;
      bus.squash_en = sq;
      rst           = r;
      if (r) model_reset();
      else   model_step(h1, h2, sq);
      push_exp();
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Monitor: every clock, compare DUT outputs against the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_pos",          int'(bus.pos),          int'(e.pos));
            chk("sb_hittable_one", int'(bus.hittable_one), int'(e.h1));
            chk("sb_hittable_two", int'(bus.hittable_two), int'(e.h2));
            chk("sb_in_play",      int'(bus.in_play),      int'(e.ip));
            chk("sb_point_one",    int'(bus.point_one),    int'(e.p1));
            chk("sb_point_two",    int'(bus.point_two),    int'(e.p2));
            chk("sb_rally_cnt",    int'(bus.rally_cnt),    int'(e.rally));
         end
      end
   end

   // Hard stop if the stimulus never completes.
   initial begin
      #1000000;
      $display("FAIL timeout: stimulus did not complete");
      $fatal(1, "timeout");
   end

   // Directed scenarios followed by randomized play.
   initial begin
      bus.hit_one   = 1'b0;
      bus.hit_two   = 1'b0;
      bus.squash_en = 1'b0;
      model_reset();

      cycle(0, 0, 0, 1);
      #1;
      chk("rst_pos",      int'(bus.pos),       1);
      chk("rst_in_play",  int'(bus.in_play),   0);
      chk("rst_rally",    int'(bus.rally_cnt), 0);
      cycle(0, 0, 0, 0);

      // Serve by player one and stepping at the initial period.
      cycle(1, 0, 0, 0); settle();
      chk("serve_in_play", int'(bus.in_play), 1);
      chk("serve_pos",     int'(bus.pos),     'h01);
      repeat (3) cycle(0, 0, 0, 0);
      settle(); chk("step_not_early", int'(bus.pos), 'h01);
      cycle(0, 0, 0, 0); settle(); chk("first_step_4clk", int'(bus.pos), 'h02);
      repeat (23) cycle(0, 0, 0, 0);
      settle(); chk("pos_0x40_27clk", int'(bus.pos), 'h40);
      cycle(0, 0, 0, 0); settle(); chk("pos_0x80_28clk", int'(bus.pos), 'h80);

      // Player two misses.
      repeat (3) cycle(0, 0, 0, 0);
      settle(); chk("no_point_early", int'(bus.point_one), 0);
      cycle(0, 0, 0, 0); settle();
      chk("miss_point_one", int'(bus.point_one), 1);
      chk("miss_pos",       int'(bus.pos),       'h80);
      chk("miss_in_play",   int'(bus.in_play),   0);
      cycle(1, 0, 0, 0); settle();
      chk("point_one_one_cycle",   int'(bus.point_one), 0);
      chk("serve_two_ignores_one", int'(bus.in_play),   0);

      // Player two serves, player one misses, service alternates back.
      cycle(0, 1, 0, 0); settle();
      chk("serve_two_in_play", int'(bus.in_play), 1);
      for (int i = 0; i < 60 && m_p2 == 0; i++) cycle(0, 0, 0, 0);
      settle();
      chk("miss_point_two", int'(bus.point_two), 1);
      chk("alt_serve_pos",  int'(bus.pos),       'h01);

      // Returns with speed-up down to the floor.
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 60 && m_ball != 6; i++) cycle(0, 0, 0, 0);
      settle();
      chk("window_pos",          int'(bus.pos),          'h40);
      chk("window_hittable_two", int'(bus.hittable_two), 1);
      cycle(0, 1, 0, 0); settle();
      chk("ret_in_play",      int'(bus.in_play),      1);
      chk("ret_rally",        int'(bus.rally_cnt),    1);
      chk("ret_pos",          int'(bus.pos),          'h40);
      chk("ret_hittable_two", int'(bus.hittable_two), 0);
      repeat (2) cycle(0, 0, 0, 0);
      settle(); chk("period3_hold", int'(bus.pos), 'h40);
      cycle(0, 0, 0, 0); settle(); chk("period3_step", int'(bus.pos), 'h20);
      for (int i = 0; i < 60 && m_ball != 1; i++) cycle(0, 0, 0, 0);
      cycle(1, 0, 0, 0); settle(); chk("ret2_rally", int'(bus.rally_cnt), 2);
      for (int i = 0; i < 60 && !(m_ball == 6 && m_dir == 1); i++) cycle(0, 0, 0, 0);
      cycle(0, 1, 0, 0); settle(); chk("ret3_rally", int'(bus.rally_cnt), 3);
      cycle(0, 0, 0, 0); settle(); chk("floor_hold", int'(bus.pos), 'h40);
      cycle(0, 0, 0, 0); settle(); chk("floor_step", int'(bus.pos), 'h20);

      // Return in the same cycle as the tick at the far end.
      for (int i = 0; i < 60 && !(m_ball == 1 && m_dir == -1); i++) cycle(0, 0, 0, 0);
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 60 && !(m_ball == 7 && m_dir == 1 && m_wait == 1); i++) cycle(0, 0, 0, 0);
      cycle(0, 1, 0, 0); settle();
      chk("tick_hit_pos",     int'(bus.pos),     'h80);
      chk("tick_hit_in_play", int'(bus.in_play), 1);
      cycle(0, 0, 0, 0); settle(); chk("tick_hit_hold", int'(bus.pos), 'h80);
      cycle(0, 0, 0, 0); settle(); chk("tick_hit_step", int'(bus.pos), 'h40);

      // Squash: player one misses and still serves next.
      for (int i = 0; i < 60 && m_p2 == 0; i++) cycle(0, 0, 1, 0);
      settle();
      chk("squash_point_two", int'(bus.point_two), 1);
      chk("squash_pos",       int'(bus.pos),       'h01);
      chk("squash_in_play",   int'(bus.in_play),   0);
      cycle(0, 1, 0, 0); settle(); chk("squash_ignores_two", int'(bus.in_play), 0);

      // Hit outside the window is ignored; reset mid-rally scores nothing.
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 60 && m_ball != 4; i++) cycle(0, 0, 0, 0);
      cycle(1, 1, 0, 0); settle();
      chk("ignored_in_play", int'(bus.in_play),   1);
      chk("ignored_rally",   int'(bus.rally_cnt), 0);
      chk("ignored_pos",     int'(bus.pos),       'h10);
      cycle(0, 0, 0, 1);
      #1;
      chk("midrst_pos",     int'(bus.pos),     'h01);
      chk("midrst_in_play", int'(bus.in_play), 0);
      settle();
      chk("midrst_no_point_one", int'(bus.point_one), 0);
      chk("midrst_no_point_two", int'(bus.point_two), 0);
      cycle(0, 0, 0, 0);

      // Randomized play with occasional squash and resets.
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 249) == 0);

      cycle(0, 0, 0, 0);
      settle();
      chk("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ball_track.md
BALL_TRACK -- requirements
Module: ball_track

Interface
REQ-001 SHALL provide parameter N_POS, default 16: number of court positions (LEDs), minimum 4.
REQ-002 SHALL provide parameter CNT_W, default 25: width of the step-period counter.
REQ-003 SHALL provide parameter INIT_PERIOD, default 2^25-1: clocks per step at serve.
REQ-004 SHALL provide parameter SPEED_STEP, default 3355443: period reduction per successful return.
REQ-005 SHALL provide parameter MIN_PERIOD, default 2: floor for the period; MIN_PERIOD <= INIT_PERIOD.
REQ-006 SHALL provide parameter HIT_WIN, default 2: number of end positions that are hittable; 2*HIT_WIN <= N_POS.
REQ-007 SHALL provide the following ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- hit_one  in  1  player-one button pulse (serve or return).
- hit_two  in  1  player-two button pulse (serve or return).
- squash_en  in  1  when 1, player one always serves.
- pos  out  N_POS  one-hot ball position; bit 0 is player one's end.
- hittable_one  out  1  ball is in player one's window and moving toward player one.
- hittable_two  out  1  ball is in player two's window and moving toward player two.
- in_play  out  1  rally in progress.
- point_one  out  1  one-cycle pulse: player one wins the point.
- point_two  out  1  one-cycle pulse: player two wins the point.
- rally_cnt  out  8  number of returns in the current rally, saturating at 255.

Function
REQ-008 SHALL implement the states SERVE_ONE, SERVE_TWO, MOVE_R (toward player two) and MOVE_L (toward player one).
REQ-009 SHALL, in SERVE_ONE, hold the ball at idx 0; hit_one SHALL move to MOVE_R and clear the counter; hit_two SHALL be ignored.
REQ-010 SHALL, in SERVE_TWO, hold the ball at idx N_POS-1; hit_two SHALL move to MOVE_L and clear the counter; hit_one SHALL be ignored.
REQ-011 SHALL keep period and rally_cnt at INIT_PERIOD and 0 in both serve states.
REQ-012 SHALL, while moving, increment the counter each clock and assert an internal tick when counter == period-1.
REQ-013 SHALL clear the counter to 0 on every tick.
REQ-014 SHALL, on a tick in MOVE_R with idx < N_POS-1, set idx+1; on a tick in MOVE_L with idx > 0, set idx-1.
REQ-015 SHALL drive hittable_two = (state==MOVE_R && idx >= N_POS-HIT_WIN) and hittable_one = (state==MOVE_L && idx < HIT_WIN), combinationally from registered state.
REQ-016 SHALL handle a return: hit_two while hittable_two:
- switch to MOVE_L; position unchanged; counter cleared;
- period = max(period-SPEED_STEP, MIN_PERIOD), computed without underflow;
- rally_cnt+1, saturating.
REQ-017 SHALL handle hit_one while hittable_one symmetrically: switch to MOVE_R, same period and rally_cnt update.
REQ-018 SHALL ignore a hit pulse when the corresponding hittable output is 0 (no penalty).
REQ-019 SHALL give a valid hit priority over a tick in the same cycle: direction reverses and no step is taken.
REQ-020 SHALL treat a miss as a tick at idx N_POS-1 in MOVE_R: pulse point_one for 1 cycle and enter the next serve state.
REQ-021 SHALL treat a tick at idx 0 in MOVE_L as a miss: pulse point_two for 1 cycle and enter the next serve state.
REQ-022 SHALL select the next serve state as follows:
- squash_en = 1: always SERVE_ONE;
- otherwise: the opposite of the previous server.
REQ-023 SHALL place pos at the serving end in the same cycle the serve state is entered.
REQ-024 SHALL drive in_play = 1 exactly in MOVE_R and MOVE_L.
REQ-025 SHALL keep pos always one-hot.

Reset
REQ-026 SHALL, on rst, asynchronously set: state SERVE_ONE, pos = 1, previous server = two, period = INIT_PERIOD, counter 0, rally_cnt 0, all 1-bit outputs 0.
REQ-027 SHALL abandon any rally in progress on a mid-rally rst, without pulsing point_one or point_two.

Verification (N_POS=8, INIT_PERIOD=4, SPEED_STEP=1, MIN_PERIOD=2, HIT_WIN=2)
REQ-028 SHALL cover serve: reset, hit_one pulse -> in_play=1; pos 0x01 -> 0x02 four clocks later; 0x80 reached 28 clocks after serve.
REQ-029 SHALL cover a miss: no return after REQ-028 -> 4 clocks after reaching 0x80, point_one=1 for 1 cycle, pos=0x80, state SERVE_TWO, in_play=0.
REQ-030 SHALL cover a return with speed-up: hit_two at pos 0x40 with hittable_two=1 -> MOVE_L, rally_cnt=1, period 3; after two more returns period stays 2.
REQ-031 SHALL cover a hit coincident with a tick: hit_two at pos 0x80 in the tick cycle -> pos stays 0x80 that cycle and then steps to 0x40.
REQ-032 SHALL cover squash mode: squash_en=1, player one misses -> point_two pulse, next state SERVE_ONE, pos=0x01.
REQ-033 SHALL cover an ignored hit and reset: hit_one at pos 0x10 moving right -> no change; rst mid-rally -> pos=0x01, no point pulse.
